rgmii_inband_status: RTL and testbench

Decodes RGMII in-band link status carried on RXD[3:0] during inter-frame gaps and produces filtered one-hot speed, link, and duplex flags. Runs in the RX clock domain, directly downstream of the RGMII DDR input capture. Its speed/link outputs are the unsynchronized rx_speed_*/rx_link_up inputs of the TX clock manager. A nibble is only committed after it persists, so single-sample glitches never reach the clock-switch logic.

---
 rtl/rgmii_pkg.sv | 45 ++++
 rtl/persistence_filter.sv | 41 ++++
 rtl/rgmii_inband_status.sv | 91 +++++++++
 tb/tb_rgmii_inband_status.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and helpers for decoding the RGMII in-band status nibble
// sent on RXD during inter-frame gaps.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'd0,
    SPEED_100  = 2'd1,
    SPEED_1000 = 2'd2
  } speed_t;

  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } inband_status_t;

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_VALID   = 2'd1,
    S_STALE   = 2'd2
  } ibs_state_t;

  localparam logic [1:0] SPEED_RESERVED = 2'b11;
  localparam int BIT_LINK     = 0;
  localparam int BIT_SPEED_LO = 1;
  localparam int BIT_SPEED_HI = 2;
  localparam int BIT_DUPLEX   = 3;

  // An inter-frame sample is usable only if both edges agree and the speed code is defined.
  function automatic logic sample_is_valid(input logic ctl_rise, input logic ctl_fall,
                                           input logic [3:0] rise, input logic [3:0] fall);
    return !ctl_rise && !ctl_fall && (rise == fall) &&
           (rise[BIT_SPEED_HI:BIT_SPEED_LO] != SPEED_RESERVED);
  endfunction

  // Returns {speed_1000, speed_100, speed_10}; the reserved code is never committed.
  function automatic logic [2:0] speed_onehot(input logic [1:0] code);
    case (speed_t'(code))
      SPEED_10:  return 3'b001;
      SPEED_100: return 3'b010;
      default:   return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/persistence_filter.sv
// Generic candidate/agree-count debouncer: hit is high the cycle after a valid
// sample leaves AGREE_COUNT consecutive identical samples behind it.
module persistence_filter #(
  parameter int W           = 4,
  parameter int AGREE_COUNT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_en,
  input  logic         sample_bad,
  input  logic [W-1:0] sample,
  output logic [W-1:0] candidate,
  output logic         hit
);
  localparam int CW = $clog2(AGREE_COUNT + 1);
  localparam logic [CW-1:0] AGREE_MAX = CW'(AGREE_COUNT);

  logic [CW-1:0] count;

  // Track the run length of identical valid samples; bad samples break the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= {W{1'b0}};
      count     <= {CW{1'b0}};
      hit       <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (sample_en) begin
        if (sample == candidate) begin
          if (count != AGREE_MAX) count <= count + CW'(1);
          hit <= (count == AGREE_MAX - CW'(1)) || (count == AGREE_MAX);
        end else begin
          candidate <= sample;
          count     <= CW'(1);
        end
      end else if (sample_bad) begin
        count <= {CW{1'b0}};
      end
    end
  end
endmodule

// File: rtl/rgmii_inband_status.sv
// Filters the RGMII in-band status nibble into committed one-hot speed, link and
// duplex flags, declaring the status stale when inter-frame samples stop.
module rgmii_inband_status
  import rgmii_pkg::*;
#(
  parameter int AGREE_COUNT    = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_ctl_rise,
  input  logic       rx_ctl_fall,
  input  logic [3:0] rxd_rise,
  input  logic [3:0] rxd_fall,
  output logic       rx_speed_10,
  output logic       rx_speed_100,
  output logic       rx_speed_1000,
  output logic       rx_link_up,
  output logic       rx_full_duplex,
  output logic       status_valid,
  output logic       status_change
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam inband_status_t RESET_STATUS = '{duplex: 1'b0, speed: SPEED_1000, link: 1'b0};

  logic           sample_valid;
  logic           sample_bad;
  logic [3:0]     cand_bits;
  logic           hit;
  inband_status_t cand;
  inband_status_t committed;
  ibs_state_t     state;
  logic [TW-1:0]  timer;
  logic           do_commit;
  logic           do_stale;

  persistence_filter #(.W(4), .AGREE_COUNT(AGREE_COUNT)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (sample_valid),
    .sample_bad (sample_bad),
    .sample     (rxd_rise),
    .candidate  (cand_bits),
    .hit        (hit)
  );

  // Classify this cycle's sample and decide between commit and timeout; commit wins.
  always_comb begin
    sample_valid = sample_is_valid(rx_ctl_rise, rx_ctl_fall, rxd_rise, rxd_fall);
    sample_bad   = !rx_ctl_rise && !rx_ctl_fall && !sample_valid;
    cand         = inband_status_t'(cand_bits);
    do_commit    = hit && ((cand != committed) || (state != S_VALID));
    do_stale     = (state == S_VALID) && (timer == TMAX) && !do_commit;
  end

  // Status state machine, staleness timer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_UNKNOWN;
      timer          <= {TW{1'b0}};
      committed      <= RESET_STATUS;
      rx_speed_10    <= 1'b0;
      rx_speed_100   <= 1'b0;
      rx_speed_1000  <= 1'b1;
      rx_link_up     <= 1'b0;
      rx_full_duplex <= 1'b0;
      status_valid   <= 1'b0;
      status_change  <= 1'b0;
    end else begin
      if (sample_valid) timer <= {TW{1'b0}};
      else if (timer != TMAX) timer <= timer + TW'(1);
      status_change <= 1'b0;
      if (do_commit) begin
        state          <= S_VALID;
        committed      <= cand;
        {rx_speed_1000, rx_speed_100, rx_speed_10} <= speed_onehot(cand.speed);
        rx_link_up     <= cand.link;
        rx_full_duplex <= cand.duplex;
        status_valid   <= 1'b1;
        status_change  <= (cand != committed);
      end else if (do_stale) begin
        state          <= S_STALE;
        committed.link <= 1'b0;
        rx_link_up     <= 1'b0;
        status_valid   <= 1'b0;
        status_change  <= committed.link;
      end
    end
  end
endmodule

// File: tb/tb_rgmii_inband_status.sv
// Randomized bench for rgmii_inband_status with a per-cycle reference model
// and a few hand-computed expectations.
module tb_rgmii_inband_status;
  localparam int A  = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cr = 1'b1, cf = 1'b0;
  logic [3:0] rr = 4'd0, rf = 4'd0;
  logic s10, s100, s1000, link, dup, sv, sc;

  rgmii_inband_status #(.AGREE_COUNT(A), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_ctl_rise(cr), .rx_ctl_fall(cf),
    .rxd_rise(rr), .rxd_fall(rf),
    .rx_speed_10(s10), .rx_speed_100(s100), .rx_speed_1000(s1000),
    .rx_link_up(link), .rx_full_duplex(dup), .status_valid(sv), .status_change(sc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pulses = 0;

  // Reference model: run length of identical gap samples, age since last good sample.
  logic [3:0] m_cand;
  int         m_run, m_age, m_state;  // state: 0 unknown, 1 valid, 2 stale
  bit         m_hit, m_valid, m_change;
  logic [3:0] m_out;                  // committed nibble as seen on outputs

  function automatic void model_reset();
    m_cand = 4'd0; m_run = 0; m_age = 0; m_state = 0;
    m_hit = 1'b0; m_valid = 1'b0; m_change = 1'b0; m_out = 4'b0100;
  endfunction

  function automatic void model_clock(logic c_r, logic c_f, logic [3:0] d_r, logic [3:0] d_f);
    logic [1:0] spd;
    bit good, bad;
    spd  = d_r[2:1];
    good = !c_r && !c_f && (d_r == d_f) && (spd != 2'b11);
    bad  = !c_r && !c_f && !good;
    m_change = 1'b0;
    if (m_hit && (m_cand != m_out || m_state != 1)) begin
      m_change = (m_cand != m_out);
      m_out = m_cand; m_state = 1; m_valid = 1'b1;
    end else if (m_state == 1 && m_age == TO) begin
      m_change = m_out[0];
      m_out[0] = 1'b0; m_state = 2; m_valid = 1'b0;
    end
    if (good) begin
      if (d_r == m_cand) begin
        m_run = (m_run < A) ? m_run + 1 : A;
        m_hit = (m_run == A);
      end else begin
        m_cand = d_r; m_run = 1; m_hit = 1'b0;
      end
      m_age = 0;
    end else begin
      m_hit = 1'b0;
      if (bad) m_run = 0;
      m_age = (m_age < TO) ? m_age + 1 : TO;
    end
  endfunction

  function automatic logic [6:0] model_vec();
    logic [2:0] oh;
    oh = 3'b001 << m_out[2:1];
    return {oh[0], oh[1], oh[2], m_out[0], m_out[3], m_valid, m_change};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c_r, input logic c_f, input logic [3:0] d_r, input logic [3:0] d_f);
    cr = c_r; cf = c_f; rr = d_r; rf = d_f;
    @(posedge clk);
    if (reset_n) model_clock(c_r, c_f, d_r, d_f);
    else model_reset();
    #1;
    check("cycle", {25'd0, s10, s100, s1000, link, dup, sv, sc}, {25'd0, model_vec()});
    pulses += int'(sc);
  endtask

  task automatic sample(input logic [3:0] n, input int times);
    for (int i = 0; i < times; i++) step(1'b0, 1'b0, n, n);
  endtask

  task automatic frame(input int times);
    for (int i = 0; i < times; i++) step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
  endtask

  task automatic rand_phase(input int n);
    logic [3:0] target, x;
    int kind;
    target = 4'b1011;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        target = 4'($urandom);
        if (target[2:1] == 2'b11) target[2] = 1'b0;
      end
      kind = $urandom_range(0, 19);
      x = 4'($urandom);
      if (kind <= 12) sample(target, 1);
      else if (kind <= 14) frame(1);
      else if (kind == 15) step(1'b0, 1'b1, x, x);
      else if (kind == 16) step(1'b0, 1'b0, x, x ^ 4'(1 << $urandom_range(0, 3)));
      else if (kind == 17) step(1'b0, 1'b0, x | 4'b0110, x | 4'b0110);
      else if (kind == 18) step(1'b0, 1'b0, x, x);
      else if ($urandom_range(0, 3) == 0) frame(120);
      else frame(1);
    end
  endtask

  initial begin
    model_reset();
    frame(3);
    check("reset_outputs", {25'd0, s10, s100, s1000, link, dup, sv, sc}, 32'b0010000);
    reset_n = 1'b1;

    // 1000/up/full committed AGREE_COUNT+1 clocks after the first sample
    pulses = 0;
    sample(4'b1101, A);
    check("t1_not_yet", {31'd0, sv}, 32'd0);
    frame(1);
    check("t1_commit", {25'd0, s10, s100, s1000, link, dup, sv, sc}, 32'b0011111);
    frame(1);
    check("t1_one_pulse", pulses, 32'd1);

    // a frame cycle in the run does not break persistence
    pulses = 0;
    sample(4'b1011, 7); frame(1); sample(4'b1011, 1); frame(1);
    check("t2_commit_100", {25'd0, s10, s100, s1000, link, dup, sv, sc}, 32'b0101111);
    check("t2_one_pulse", pulses, 32'd1);

    // glitch restarts the run; no commit of either nibble
    pulses = 0;
    sample(4'b0001, 3); sample(4'b0011, 1); sample(4'b0001, 4); frame(4);
    check("t3_hold_100", {29'd0, s10, s100, s1000}, 32'b010);
    check("t3_no_pulse", pulses, 32'd0);

    // edge mismatches and reserved speed never commit
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'b1101, 4'b1100);
      step(1'b0, 1'b0, 4'b0111, 4'b0111);
    end
    check("t4_no_pulse", pulses, 32'd0);

    // staleness and recovery
    sample(4'b1101, A); frame(1);
    pulses = 0;
    frame(TO + 10);
    check("t5_stale", {25'd0, s10, s100, s1000, link, dup, sv}, 32'b001010);
    check("t5_stale_pulse", pulses, 32'd1);
    pulses = 0;
    sample(4'b1101, A); frame(1);
    check("t5_recover", {29'd0, link, sv, dup}, 32'b111);
    check("t5_recover_pulse", pulses, 32'd1);

    rand_phase(700);

    // asynchronous reset mid-cycle
    sample(4'b1001, A + 1);
    #($urandom_range(1, 3));
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", {25'd0, s10, s100, s1000, link, dup, sv, sc}, 32'b0010000);
    model_reset();
    frame(2);
    reset_n = 1'b1;
    rand_phase(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
